// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: scan FSM states and
// the active-high hex glyph table, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } seg7_state_e;

   localparam logic [6:0] SEG7_BLANK = 7'h00;

   localparam logic [6:0] SEG7_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational hex-nibble to active-high segment encoder with a blank
// override; shared by the display blocks.
module seg7_hex_enc
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG7_BLANK : SEG7_FONT[nibble];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment scanner: snapshots a packed hex value, scans one
// digit per slot with a leading blank interval, optional leading-zero blanking.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] value_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic                  load_i,
   input  logic                  en_i,
   input  logic                  lzs_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [N_DIGITS-1:0]   an_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam seg7_state_e      SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   logic [4*N_DIGITS-1:0] val_q;
   logic [N_DIGITS-1:0]   dp_q;

   seg7_state_e           state;
   seg7_state_e           state_d;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_d;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_d;
   logic                  enter_show;

   logic [3:0]            nibbles [N_DIGITS];
   logic [N_DIGITS-1:0]   zero_from;
   logic [3:0]            next_nib;
   logic                  next_dp;
   logic                  next_blank;

   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [6:0]            glyph;

   logic [6:0]            seg_act;
   logic                  dp_act;
   logic [N_DIGITS-1:0]   an_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
         dp_q  <= '0;
      end else if (load_i) begin
         val_q <= value_i;
         dp_q  <= dp_i;
      end
   end

   // The slot counter runs across the whole slot; blank covers its low counts.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      if (!en_i) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state)
            ST_OFF: begin
               state_d = SLOT_START;
               cnt_d   = '0;
               idx_d   = '0;
            end
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_d = ST_SHOW;
               end
               cnt_d = cnt + CNT_W'(1);
            end
            ST_SHOW: begin
               if (cnt == SLOT_LAST) begin
                  state_d = SLOT_START;
                  cnt_d   = '0;
                  idx_d   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   assign enter_show = (state_d == ST_SHOW) && ((state != ST_SHOW) || (cnt == SLOT_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
      end
   end

   // zero_from[k]: every nibble from digit k up to the leftmost digit is zero.
   for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      assign nibbles[k]   = val_q[4*k +: 4];
      assign zero_from[k] = (val_q[4*N_DIGITS-1 : 4*k] == '0);
   end

   assign next_nib   = nibbles[idx_d];
   assign next_dp    = dp_q[idx_d];
   assign next_blank = lzs_i && (idx_d != '0) && zero_from[idx_d] && !next_dp;

   // Digit contents freeze at SHOW entry so a reload never tears a digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_nib   <= '0;
         cur_dp    <= 1'b0;
         cur_blank <= 1'b0;
      end else if (enter_show) begin
         cur_nib   <= next_nib;
         cur_dp    <= next_dp;
         cur_blank <= next_blank;
      end
   end

   seg7_hex_enc u_enc (
      .nibble (cur_nib),
      .blank  (cur_blank),
      .seg    (glyph)
   );

   always_comb begin
      seg_act = SEG7_BLANK;
      dp_act  = 1'b0;
      an_act  = '0;
      if ((state == ST_SHOW) && en_i) begin
         seg_act = glyph;
         dp_act  = cur_dp;
         for (int k = 0; k < N_DIGITS; k++) begin
            an_act[k] = (idx == IDX_W'(k));
         end
      end
   end

   // Pin polarity is applied only here; everything upstream is active-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_o <= {7{SEG_ACTIVE_LOW}};
         dp_o  <= SEG_ACTIVE_LOW;
         an_o  <= {N_DIGITS{AN_ACTIVE_LOW}};
      end else begin
         seg_o <= seg_act ^ {7{SEG_ACTIVE_LOW}};
         dp_o  <= dp_act ^ SEG_ACTIVE_LOW;
         an_o  <= an_act ^ {N_DIGITS{AN_ACTIVE_LOW}};
      end
   end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Time-multiplexed driver for a parametrised bank of common-anode or common-cathode 7-segment digits with decimal points. The block snapshots a packed hex value on a load strobe, scans one digit at a time at a programmable refresh rate, and inserts an anti-ghosting blank interval between digits. Optional leading-zero suppression is provided. It sits between a register or counter datapath and the board's segment and anode pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned; must be ≥1.
- `CLK_DIV`, 50000: clock cycles per digit slot, blank interval included; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles per slot with all anodes off; may be 0.
- `SEG_ACTIVE_LOW`, 1: 1 means a segment or dp pin is lit at 0.
- `AN_ACTIVE_LOW`, 1: 1 means the anode/select pin is active at 0.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `value_i`  in  4*N_DIGITS: packed nibbles; nibble k = digit k, digit 0 rightmost.
- `dp_i`  in  N_DIGITS: decimal point per digit.
- `load_i`  in  1: single-cycle strobe; captures `value_i` and `dp_i`.
- `en_i`  in  1: scan enable.
- `lzs_i`  in  1: leading-zero suppression enable.
- `seg_o`  out  7: segments {g,f,e,d,c,b,a}, bit 0 = a.
- `dp_o`  out  1: decimal point.
- `an_o`  out  N_DIGITS: digit selects, one-hot when active.

## Operation
- Snapshot registers (`val_q`, `dp_q`) reset to 0. They load in the cycle after `load_i` is high. Inputs are ignored otherwise.
- FSM states are OFF, BLANK, and SHOW. A slot counter of width $clog2(CLK_DIV) and a digit index of width $clog2(N_DIGITS), min 1, run alongside it.
  - OFF: counters are 0. If `en_i` is high, go to BLANK (or SHOW when `BLANK_CYCLES`=0).
  - BLANK: lasts `BLANK_CYCLES` cycles, then go to SHOW.
  - SHOW: lasts `CLK_DIV-BLANK_CYCLES` cycles. At the end, the digit index increments, wraps from N_DIGITS-1 to 0, and the FSM goes to BLANK.
  - `en_i` low in any state: go to OFF the next cycle, with the digit index and counter cleared.
- On entry to SHOW, the nibble, dp bit and blanking decision for the current digit are latched. A `load_i` during SHOW therefore takes effect at the next slot and never mid-digit.
- Leading-zero suppression: when `lzs_i` is high, digit k is blanked (segments and dp off, anode still active) if every nibble from k up to N_DIGITS-1 is 0 and k≠0. Digit 0 always shows. A set dp bit overrides suppression for its digit.
- Font: 0-9 and A, b, C, d, E, F in the standard hex glyphs.
- Polarity is applied at the output registers only. All internal logic is active-high.

## Timing
- All outputs are registered and reset asynchronously to inactive: `seg_o`=7'h7F, `dp_o`=1, `an_o`=all 1s (for the default polarities).
- Outputs reflect the FSM state with 1 cycle of latency. Anodes are active only during the SHOW cycles of the current digit, one-hot for that digit.
- Full scan period is N_DIGITS×CLK_DIV cycles. Per-digit duty is (CLK_DIV-BLANK_CYCLES)/(N_DIGITS×CLK_DIV).
- Reset mid-scan: outputs go inactive immediately. After release, scanning starts from digit 0 BLANK, provided `en_i` is high.
- `load_i` held high: the snapshot reloads every cycle. A load coinciding with the SHOW-entry latch uses the old snapshot for that digit.
- N_DIGITS=1: the index stays 0 and `an_o` is 1 bit.

## Structure
- Package `seg7_pkg`:
  - FSM state enum `seg7_state_e`.
  - Constant `SEG7_FONT`, a 16×7 active-high glyph array.
  - `SEG7_BLANK`, 7'h00.
- Sub-module `seg7_hex_enc`: combinational nibble plus blank to active-high segments, indexing `SEG7_FONT`. It is reused by other display blocks.
- Top level holds the FSM, counters, snapshot, suppression logic and polarity output registers.

## Test plan
Bench configuration is N_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, default polarities.
- Reset check: `rst_n` low, `en_i`=1 → `seg_o`=7'h7F, `dp_o`=1, `an_o`=4'hF. After release, `an_o`=4'hE exactly 3 cycles after the first BLANK cycle (2 blank cycles plus 1 register cycle), held for 6 cycles.
- Full scan: `load_i` with `value_i`=16'h1A3F, `dp_i`=4'b0100 →
  - digit 0 (`an_o`=4'hE): `seg_o`=7'h0E, i.e. active-low F.
  - digit 1 (`an_o`=4'hD): `seg_o`=7'h30, i.e. 3.
  - digit 2 (`an_o`=4'hB): `seg_o`=7'h08, i.e. A, and `dp_o`=0.
  - digit 3 (`an_o`=4'h7): `seg_o`=7'h79, i.e. 1.
  - Period is 32 cycles, with `an_o`=4'hF for 2 cycles between digits.
- Leading-zero suppression: `value_i`=16'h0050, `lzs_i`=1 → digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0. With `value_i`=0, only digit 0 shows 0.
- Mid-digit load: during digit 1 SHOW, load 16'hFFFF → digit 1 keeps its old glyph until its slot ends. Digit 2 shows F.
- Enable and reset mid-operation: drop `en_i` during digit 2 → `an_o`=4'hF the next cycle. Re-enable → scanning resumes at digit 0. Pulsing `rst_n` mid-SHOW gives the same result and clears the snapshot to 0.
- Polarity: rebuild with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0 → outputs are the bitwise inverse of the full-scan case, with reset values 0.
